// File: rtl/whackamole_game_core.sv
// whackamole_game_core: mole spawn, guess scoring, timeouts and LED drive.
// Define WHACKAMOLE_STREAK_BONUS_EN to score 2 per hit from the 4th in a row.
module whackamole_game_core #(
   parameter int NUM_HOLES    = 8,
   parameter int POS_W        = 3,
   parameter int SCORE_W      = 8,
   parameter int INIT_TIMEOUT = 50000000,
   parameter int MIN_TIMEOUT  = 10000000,
   parameter int TIMEOUT_STEP = 2000000,
   parameter int MAX_MISSES   = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [POS_W-1:0]     user_guess,
   input  logic                 eval_now,
   output logic [POS_W-1:0]     mole_pos,
   output logic                 mole_change,
   output logic                 guess_correct,
   output logic                 guess_wrong,
   output logic                 mole_timeout,
   output logic                 guess_now,
   output logic [SCORE_W-1:0]   score,
   output logic [3:0]           misses,
   output logic                 game_over,
   output logic [NUM_HOLES-1:0] led
);

   localparam int TW  = $clog2(INIT_TIMEOUT + 1);
   localparam int SW1 = SCORE_W + 1;
   localparam int PW1 = POS_W + 1;
   localparam logic [POS_W-1:0] LAST = POS_W'(NUM_HOLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SPAWN,
      S_ACTIVE,
      S_RESULT,
      S_OVER
   } state_t;

   state_t               state, state_d;
   logic [15:0]          lfsr;
   logic [POS_W-1:0]     pos_d, spawn_raw, spawn_pos;
   logic [TW-1:0]        timer, timer_d, cur_timeout, cur_d, cur_shrunk;
   logic [31:0]          cur_ext;
   logic [SCORE_W-1:0]   score_d;
   logic [SCORE_W:0]     score_sum, score_inc;
   logic [3:0]           misses_d;
   logic                 change_d, correct_d, wrong_d, timeout_d;
   logic                 miss_inc, hit;
   logic [NUM_HOLES-1:0] led_d;

   // Re-roll onto the neighbour hole so the mole always visibly moves
   assign spawn_raw = POS_W'(lfsr % 16'(NUM_HOLES));
   assign spawn_pos = (spawn_raw != mole_pos) ? spawn_raw :
                      (spawn_raw == LAST)     ? '0 :
                                                spawn_raw + POS_W'(1);

   assign hit = (user_guess == mole_pos) &&
                ({1'b0, user_guess} < PW1'(NUM_HOLES));

   assign cur_ext    = 32'(cur_timeout);
   assign cur_shrunk = (cur_ext >= 32'(MIN_TIMEOUT + TIMEOUT_STEP)) ?
                       cur_timeout - TW'(TIMEOUT_STEP) :
                       TW'(MIN_TIMEOUT);

   assign score_sum = {1'b0, score} + score_inc;

`ifdef WHACKAMOLE_STREAK_BONUS_EN
   logic [2:0] streak, streak_d;
   logic       new_game;

   assign new_game  = start && (state == S_IDLE || state == S_OVER);
   assign score_inc = (streak >= 3'd3) ? SW1'(2) : SW1'(1);

   always_comb begin
      streak_d = streak;
      if (new_game || wrong_d || timeout_d)
         streak_d = '0;
      else if (correct_d && streak != 3'd7)
         streak_d = streak + 3'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         streak <= '0;
      else
         streak <= streak_d;
   end
`else
   assign score_inc = SW1'(1);
`endif

   always_comb begin
      state_d   = state;
      pos_d     = mole_pos;
      timer_d   = timer;
      cur_d     = cur_timeout;
      score_d   = score;
      misses_d  = misses;
      change_d  = 1'b0;
      correct_d = 1'b0;
      wrong_d   = 1'b0;
      timeout_d = 1'b0;
      miss_inc  = 1'b0;
      unique case (state)
         S_IDLE, S_OVER: begin
            if (start) begin
               score_d  = '0;
               misses_d = '0;
               cur_d    = TW'(INIT_TIMEOUT);
               state_d  = S_SPAWN;
            end
         end
         S_SPAWN: begin
            pos_d    = spawn_pos;
            change_d = 1'b1;
            timer_d  = cur_timeout - TW'(1);
            state_d  = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (eval_now && hit) begin
               correct_d = 1'b1;
               score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
               cur_d     = cur_shrunk;
               state_d   = S_RESULT;
            end else if (eval_now) begin
               wrong_d  = 1'b1;
               miss_inc = 1'b1;
               // Timer parks at zero so a late wrong guess still times out
               if (timer != '0)
                  timer_d = timer - TW'(1);
            end else if (timer == '0) begin
               timeout_d = 1'b1;
               miss_inc  = 1'b1;
               state_d   = S_SPAWN;
            end else begin
               timer_d = timer - TW'(1);
            end
            if (miss_inc) begin
               misses_d = misses + 4'd1;
               if (misses_d == 4'(MAX_MISSES))
                  state_d = S_OVER;
            end
         end
         S_RESULT: state_d = S_SPAWN;
         default:  state_d = S_IDLE;
      endcase

      unique case (state_d)
         S_SPAWN, S_ACTIVE: led_d = NUM_HOLES'(1) << pos_d;
         S_RESULT, S_OVER:  led_d = '1;
         default:           led_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         lfsr          <= 16'hACE1;
         mole_pos      <= '0;
         timer         <= '0;
         cur_timeout   <= TW'(INIT_TIMEOUT);
         score         <= '0;
         misses        <= '0;
         mole_change   <= 1'b0;
         guess_correct <= 1'b0;
         guess_wrong   <= 1'b0;
         mole_timeout  <= 1'b0;
         guess_now     <= 1'b0;
         game_over     <= 1'b0;
         led           <= '0;
      end else begin
         state         <= state_d;
         lfsr          <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         mole_pos      <= pos_d;
         timer         <= timer_d;
         cur_timeout   <= cur_d;
         score         <= score_d;
         misses        <= misses_d;
         mole_change   <= change_d;
         guess_correct <= correct_d;
         guess_wrong   <= wrong_d;
         mole_timeout  <= timeout_d;
         guess_now     <= (state_d == S_ACTIVE);
         game_over     <= (state_d == S_OVER);
         led           <= led_d;
      end
   end

endmodule

// File: tb/tb_whackamole_game_core.sv
// tb_whackamole_game_core: directed checks of spawn, hit, miss, timeout,
// game over, saturation and reset with a small reference model.
module tb_whackamole_game_core;

   localparam int NH   = 5;
   localparam int PW   = 3;
   localparam int SW   = 4;
   localparam int INIT = 10;
   localparam int MINT = 4;
   localparam int STEP = 3;
   localparam int MAXM = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [PW-1:0] user_guess = '0;
   logic          eval_now = 1'b0;
   logic [PW-1:0] mole_pos;
   logic          mole_change, guess_correct, guess_wrong, mole_timeout;
   logic          guess_now, game_over;
   logic [SW-1:0] score;
   logic [3:0]    misses;
   logic [NH-1:0] led;

   int checks   = 0;
   int failures = 0;
   int mpos     = 0;
   int exp_score = 0;
   int exp_miss  = 0;
   int streak    = 0;

   logic [15:0] m_lfsr, lfsr_prev;

   whackamole_game_core #(
      .NUM_HOLES(NH), .POS_W(PW), .SCORE_W(SW),
      .INIT_TIMEOUT(INIT), .MIN_TIMEOUT(MINT),
      .TIMEOUT_STEP(STEP), .MAX_MISSES(MAXM)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .user_guess(user_guess), .eval_now(eval_now),
      .mole_pos(mole_pos), .mole_change(mole_change),
      .guess_correct(guess_correct), .guess_wrong(guess_wrong),
      .mole_timeout(mole_timeout), .guess_now(guess_now),
      .score(score), .misses(misses), .game_over(game_over),
      .led(led)
   );

   always #5 clk = ~clk;

   // Reference LFSR: lfsr_prev holds the value seen during the last cycle
   always @(posedge clk) begin
      lfsr_prev <= m_lfsr;
      if (rst)
         m_lfsr <= 16'hACE1;
      else
         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int nxt_pos(input logic [15:0] l, input int old);
      int p;
      p = int'(l % 16'd5);
      if (p == old)
         p = (p + 1) % NH;
      return p;
   endfunction

   task automatic expect_spawn(input string tag);
      mpos = nxt_pos(lfsr_prev, mpos);
      check({tag, "_chg"}, int'(mole_change), 1);
      check({tag, "_pos"}, int'(mole_pos), mpos);
      check({tag, "_led"}, int'(led), 1 << mpos);
      check({tag, "_gnow"}, int'(guess_now), 1);
   endtask

   task automatic hit(input string tag);
      int inc;
      user_guess = PW'(mpos);
      eval_now = 1'b1;
      tick();
      eval_now = 1'b0;
      inc = 1;
`ifdef WHACKAMOLE_STREAK_BONUS_EN
      if (streak >= 3)
         inc = 2;
      if (streak < 7)
         streak++;
`endif
      exp_score = (exp_score + inc > 15) ? 15 : exp_score + inc;
      check({tag, "_corr"}, int'(guess_correct), 1);
      check({tag, "_score"}, int'(score), exp_score);
      check({tag, "_tmo"}, int'(mole_timeout), 0);
      check({tag, "_miss"}, int'(misses), exp_miss);
      check({tag, "_led"}, int'(led), 31);
      tick();
      check({tag, "_pulse"}, int'(guess_correct), 0);
      tick();
      expect_spawn(tag);
   endtask

   task automatic wrong(input string tag, input int g);
      user_guess = PW'(g);
      eval_now = 1'b1;
      tick();
      eval_now = 1'b0;
      exp_miss++;
      streak = 0;
      check({tag, "_wrong"}, int'(guess_wrong), 1);
      check({tag, "_miss"}, int'(misses), exp_miss);
      check({tag, "_pos"}, int'(mole_pos), mpos);
      check({tag, "_chg"}, int'(mole_change), 0);
      check({tag, "_gnow"}, int'(guess_now), 1);
   endtask

   task automatic wait_timeout(input string tag, input int life);
      int n;
      bit seen;
      n = 0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (guess_now)
            n++;
         tick();
         if (mole_timeout) begin
            seen = 1;
            break;
         end
      end
      exp_miss++;
      streak = 0;
      check({tag, "_seen"}, int'(seen), 1);
      check({tag, "_life"}, n, life);
      check({tag, "_miss"}, int'(misses), exp_miss);
      check({tag, "_gnow"}, int'(guess_now), 0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_pos"}, int'(mole_pos), 0);
      check({tag, "_pulses"},
            int'({mole_change, guess_correct, guess_wrong, mole_timeout}), 0);
      check({tag, "_score"}, int'(score), 0);
      check({tag, "_miss"}, int'(misses), 0);
      check({tag, "_over"}, int'(game_over), 0);
      check({tag, "_led"}, int'(led), 0);
      check({tag, "_gnow"}, int'(guess_now), 0);
   endtask

   initial begin
      tick();
      tick();
      check_reset("rst");
      rst = 1'b0;
      tick();
      check("idle_led", int'(led), 0);

      // Game 1: fresh timeout, three hits, ignored start, wrong, game over
      start = 1'b1;
      tick();
      start = 1'b0;
      check("spawn_gnow", int'(guess_now), 0);
      check("spawn_chg", int'(mole_change), 0);
      check("spawn_led", int'(led), 1);
      tick();
      expect_spawn("first");
      wait_timeout("to10", INIT);
      tick();
      expect_spawn("after_to");
      hit("hit1");
      hit("hit2");
      hit("hit3");
      start = 1'b1;
      tick();
      start = 1'b0;
      check("ign_start_chg", int'(mole_change), 0);
      check("ign_start_gnow", int'(guess_now), 1);
      check("ign_start_score", int'(score), exp_score);
      wrong("bad6", 6);
      wait_timeout("to4", 2);
      check("over_flag", int'(game_over), 1);
      check("over_led", int'(led), 31);
      check("over_score", int'(score), exp_score);
      user_guess = PW'(mpos);
      eval_now = 1'b1;
      tick();
      eval_now = 1'b0;
      check("over_eval", int'({guess_correct, guess_wrong}), 0);
      check("over_miss", int'(misses), MAXM);
      tick();
      check("over_hold", int'(game_over), 1);

      // Game 2: restart, hit on the last mole cycle, saturation, reset
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_score = 0;
      exp_miss = 0;
      streak = 0;
      check("restart_score", int'(score), 0);
      check("restart_miss", int'(misses), 0);
      check("restart_over", int'(game_over), 0);
      tick();
      expect_spawn("g2");
      hit("g2hit");
      for (int i = 0; i < 6; i++)
         tick();
      check("t0_gnow", int'(guess_now), 1);
      hit("t0hit");
      for (int i = 0; i < 20; i++)
         hit("sat");
      check("sat_score", int'(score), 15);
      wrong("streak_clr", 7);
      rst = 1'b1;
      tick();
      mpos = 0;
      check_reset("midrst");
      rst = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      expect_spawn("reseed");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
